// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for a 5-stage RV32I pipeline.
// This block holds the PC and picks the next PC from PCSrcE. It captures the fetched
// instruction for decode, flags misaligned redirect targets (a sticky error) and
// keeps a saturating count of taken redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       PCSrcE,
    input  logic [31:0]      PCTargetE,
    input  logic [31:0]      ALUResultE,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [31:0]      InstrF,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCD,
    output logic [31:0]      PCPlus4D,
    output logic             validD,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pcd_q, pcd_d;
    logic [31:0]      pc4d_q, pc4d_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      pc_plus4;
    logic             redirect;
    logic [31:0]      target;

    assign pc_plus4 = pc_q + 32'd4;

    // Decode the next-PC select: 01 = branch/JAL target, 10 = JALR target (bit0 cleared).
    // 11 is reserved and behaves as sequential.
    always_comb begin
        redirect = 1'b0;
        target   = PCTargetE;
        case (PCSrcE)
            2'b01: begin
                redirect = 1'b1;
                target   = PCTargetE;
            end
            2'b10: begin
                redirect = 1'b1;
                target   = ALUResultE & 32'hFFFF_FFFE;
            end
            default: begin
                redirect = 1'b0;
                target   = PCTargetE;
            end
        endcase
    end

    // Next PC, sticky misalignment flag and the saturating redirect counter.
    // A redirect overrides StallF; the target is always forced word-aligned.
    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        cnt_d = cnt_q;
        if (redirect) begin
            pc_d = {target[31:2], 2'b00};
            if (target[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (!StallF) begin
            pc_d = pc_plus4;
        end
    end

    // IF/ID register next state: a flush beats a stall, and a stall beats a capture.
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pc4d_d  = pc4d_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'h0;
            pc4d_d  = 32'h0;
            valid_d = 1'b0;
        end else if (!StallD) begin
            instr_d = InstrF;
            pcd_d   = pc_q;
            pc4d_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    // State registers; reset has priority over every stall, flush and redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'h0;
            pc4d_q  <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pc4d_q  <= pc4d_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCF          = pc_q;
    assign InstrD       = instr_q;
    assign PCD          = pcd_q;
    assign PCPlus4D     = pc4d_q;
    assign validD       = valid_q;
    assign misalign_err = err_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed vector table, a misalignment hold sequence, and
// randomized traffic checked against a reference model.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE, ALUResultE;
    logic        StallF, StallD, FlushD;
    logic [31:0] InstrF;

    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        validD, misalign_err;
    logic [15:0] redirect_cnt;

    logic [31:0] PCF2, InstrD2, PCD2, PCPlus4D2;
    logic        validD2, misalign_err2;
    logic [1:0]  redirect_cnt2;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
    logic        m_valid, m_err;
    int          m_cnt;

    // instruction memory contents: a simple function of the address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign InstrF = mem(PCF);

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ALUResultE(ALUResultE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .validD(validD), .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
    );

    fetch_stage #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ALUResultE(ALUResultE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .InstrF(InstrF), .PCF(PCF2), .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2),
        .validD(validD2), .misalign_err(misalign_err2), .redirect_cnt(redirect_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: one clock edge, computed directly from the fetch rules.
    task automatic model_edge();
        logic [31:0] tgt;
        logic        redir;
        if (rst) begin
            m_pc = 32'h0; m_instr = NOP; m_pcd = 0; m_pc4d = 0;
            m_valid = 0; m_err = 0; m_cnt = 0;
        end else begin
            redir = (PCSrcE == 2'd1) || (PCSrcE == 2'd2);
            tgt   = (PCSrcE == 2'd1) ? PCTargetE : (ALUResultE / 2) * 2;
            if (FlushD) begin
                m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0;
            end else if (!StallD) begin
                m_instr = mem(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1;
            end
            if (redir) begin
                m_pc = (tgt / 4) * 4;
                if (tgt % 4 != 0) m_err = 1;
                m_cnt++;
            end else if (!StallF) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step(input logic r, input logic [1:0] s, input logic [31:0] t,
                        input logic [31:0] a, input logic sf, input logic sd, input logic fd);
        @(negedge clk);
        rst = r; PCSrcE = s; PCTargetE = t; ALUResultE = a;
        StallF = sf; StallD = sd; FlushD = fd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic compare_model();
        check("pcf_model",    PCF,          m_pc);
        check("instrd_model", InstrD,       m_instr);
        check("pcd_model",    PCD,          m_pcd);
        check("pc4d_model",   PCPlus4D,     m_pc4d);
        check("valid_model",  {31'b0, validD},       {31'b0, m_valid});
        check("err_model",    {31'b0, misalign_err}, {31'b0, m_err});
        check("cnt_model",    {16'b0, redirect_cnt}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
        check("cnt2_model",   {30'b0, redirect_cnt2}, (m_cnt > 3) ? 32'd3 : m_cnt);
    endtask

    typedef struct {
        logic        r;
        logic [1:0]  s;
        logic [31:0] t, a;
        logic        sf, sd, fd;
        logic [31:0] pcf, pcd;
        logic        v, err;
        int          cnt, cnt2;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [1:0] s, input logic [31:0] t,
                       input logic [31:0] a, input logic sf, input logic sd, input logic fd,
                       input logic [31:0] pcf, input logic [31:0] pcd, input logic v,
                       input logic err, input int cnt, input int cnt2);
        vec_t e;
        e.r = r; e.s = s; e.t = t; e.a = a; e.sf = sf; e.sd = sd; e.fd = fd;
        e.pcf = pcf; e.pcd = pcd; e.v = v; e.err = err; e.cnt = cnt; e.cnt2 = cnt2;
        vq.push_back(e);
    endtask

    initial begin
        rst = 1'b1; PCSrcE = 0; PCTargetE = 0; ALUResultE = 0;
        StallF = 0; StallD = 0; FlushD = 0;

        //  r  src tgt           alu        sf sd fd   pcf           pcd           v err cnt c2
        add(1, 0, 32'h0,        32'h0,     0, 0, 0,   32'h0,        32'h0,        0, 0, 0, 0);
        add(0, 0, 32'h0,        32'h0,     0, 0, 0,   32'h4,        32'h0,        1, 0, 0, 0);
        add(0, 0, 32'h0,        32'h0,     0, 0, 0,   32'h8,        32'h4,        1, 0, 0, 0);
        add(0, 1, 32'h40,       32'h0,     0, 0, 1,   32'h40,       32'h0,        0, 0, 1, 1);
        add(0, 0, 32'h0,        32'h0,     0, 0, 0,   32'h44,       32'h40,       1, 0, 1, 1);
        add(0, 2, 32'h0,        32'h101,   0, 0, 0,   32'h100,      32'h44,       1, 0, 2, 2);
        add(0, 2, 32'h0,        32'h102,   0, 0, 0,   32'h100,      32'h100,      1, 1, 3, 3);
        add(0, 1, 32'h1C,       32'h0,     0, 0, 1,   32'h1C,       32'h0,        0, 1, 4, 3);
        add(0, 0, 32'h0,        32'h0,     0, 0, 0,   32'h20,       32'h1C,       1, 1, 4, 3);
        add(0, 0, 32'h0,        32'h0,     1, 1, 0,   32'h20,       32'h1C,       1, 1, 4, 3);
        add(0, 0, 32'h0,        32'h0,     1, 1, 0,   32'h20,       32'h1C,       1, 1, 4, 3);
        add(0, 0, 32'h0,        32'h0,     1, 1, 0,   32'h20,       32'h1C,       1, 1, 4, 3);
        add(0, 1, 32'h80,       32'h0,     1, 0, 0,   32'h80,       32'h20,       1, 1, 5, 3);
        add(0, 0, 32'h0,        32'h0,     0, 1, 1,   32'h84,       32'h0,        0, 1, 5, 3);
        add(0, 1, 32'hFFFFFFFC, 32'h0,     0, 0, 0,   32'hFFFFFFFC, 32'h84,       1, 1, 6, 3);
        add(0, 0, 32'h0,        32'h0,     0, 0, 0,   32'h0,        32'hFFFFFFFC, 1, 1, 6, 3);
        add(1, 0, 32'h0,        32'h0,     0, 0, 0,   32'h0,        32'h0,        0, 0, 0, 0);
        add(0, 1, 32'h200,      32'h0,     0, 0, 1,   32'h200,      32'h0,        0, 0, 1, 1);
        add(0, 1, 32'h204,      32'h0,     0, 0, 1,   32'h204,      32'h0,        0, 0, 2, 2);
        add(0, 1, 32'h208,      32'h0,     0, 0, 1,   32'h208,      32'h0,        0, 0, 3, 3);
        add(0, 1, 32'h20C,      32'h0,     0, 0, 1,   32'h20C,      32'h0,        0, 0, 4, 3);
        add(0, 1, 32'h210,      32'h0,     0, 0, 1,   32'h210,      32'h0,        0, 0, 5, 3);
        add(0, 0, 32'h0,        32'h0,     1, 1, 0,   32'h210,      32'h0,        0, 0, 5, 3);
        add(1, 1, 32'h300,      32'h0,     1, 1, 0,   32'h0,        32'h0,        0, 0, 0, 0);
        add(0, 0, 32'h0,        32'h0,     0, 0, 0,   32'h4,        32'h0,        1, 0, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].s, vq[i].t, vq[i].a, vq[i].sf, vq[i].sd, vq[i].fd);
            check($sformatf("v%0d_pcf", i),   PCF,      vq[i].pcf);
            check($sformatf("v%0d_pcd", i),   PCD,      vq[i].pcd);
            check($sformatf("v%0d_instr", i), InstrD,   vq[i].v ? mem(vq[i].pcd) : NOP);
            check($sformatf("v%0d_pc4d", i),  PCPlus4D, vq[i].v ? vq[i].pcd + 32'd4 : 32'h0);
            check($sformatf("v%0d_valid", i), {31'b0, validD},       {31'b0, vq[i].v});
            check($sformatf("v%0d_err", i),   {31'b0, misalign_err}, {31'b0, vq[i].err});
            check($sformatf("v%0d_cnt", i),   {16'b0, redirect_cnt}, vq[i].cnt);
            check($sformatf("v%0d_cnt2", i),  {30'b0, redirect_cnt2}, vq[i].cnt2);
        end

        // misaligned JALR target (0x303 -> bit0 cleared -> 0x302 -> PC 0x300), error must persist
        step(0, 2, 32'h0, 32'h303, 0, 0, 0);
        check("mis_pcf", PCF, 32'h300);
        check("mis_err", {31'b0, misalign_err}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 32'h0, 32'h0, 0, 0, 0);
            check($sformatf("mis_hold%0d_err", k), {31'b0, misalign_err}, 32'd1);
            check($sformatf("mis_hold%0d_pcf", k), PCF, 32'h300 + 32'(4 * k));
        end

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0),
                 2'($urandom_range(0, 3)),
                 $urandom, $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0));
            compare_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
